// File: rtl/slip_axis_decoder_id.sv
// SLIP symbol stream to AXI-Stream packets. The first unescaped symbol of each frame becomes TID.
// Optional macro SLIP_DEC_ERR_FLAG_EN adds o_m_axis_tuser (frame escape-error flag on the tlast beat).
module slip_axis_decoder_id #(
    parameter int unsigned                 SYMBOL_WIDTH   = 8,
    parameter int unsigned                 TID_WIDTH      = 4,
    parameter logic [SYMBOL_WIDTH-1:0]     SYMBOL_END     = SYMBOL_WIDTH'(8'hC0),
    parameter logic [SYMBOL_WIDTH-1:0]     SYMBOL_ESC     = SYMBOL_WIDTH'(8'hDB),
    parameter logic [SYMBOL_WIDTH-1:0]     SYMBOL_ESC_END = SYMBOL_WIDTH'(8'hDC),
    parameter logic [SYMBOL_WIDTH-1:0]     SYMBOL_ESC_ESC = SYMBOL_WIDTH'(8'hDD)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_s_axis_tvalid,
    output logic                    o_s_axis_tready,
    input  logic [SYMBOL_WIDTH-1:0] i_s_axis_tdata,
    output logic                    o_m_axis_tvalid,
    input  logic                    i_m_axis_tready,
    output logic [SYMBOL_WIDTH-1:0] o_m_axis_tdata,
    output logic [TID_WIDTH-1:0]    o_m_axis_tid,
    output logic                    o_m_axis_tlast
`ifdef SLIP_DEC_ERR_FLAG_EN
    ,
    output logic                    o_m_axis_tuser
`endif
);

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_ID,
        ST_ID_ESC,
        ST_DATA,
        ST_DATA_ESC
    } state_e;

    state_e                  state_q,    state_d;
    logic [TID_WIDTH-1:0]    tid_q,      tid_d;
    logic [SYMBOL_WIDTH-1:0] la_q,       la_d;
    logic                    la_vld_q,   la_vld_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic [SYMBOL_WIDTH-1:0] m_tdata_q,  m_tdata_d;
    logic [TID_WIDTH-1:0]    m_tid_q,    m_tid_d;
    logic                    m_tlast_q,  m_tlast_d;
`ifdef SLIP_DEC_ERR_FLAG_EN
    logic                    err_q,      err_d;
    logic                    m_tuser_q,  m_tuser_d;
    logic                    esc_err;
`endif

    logic                    accept;
    logic                    is_payload;
    logic                    is_end;
    logic [SYMBOL_WIDTH-1:0] sym;
    logic [SYMBOL_WIDTH-1:0] sym_res;

    // The output register can take a new beat whenever it is empty or draining this cycle.
    assign o_s_axis_tready = !m_tvalid_q || i_m_axis_tready;
    assign accept          = i_s_axis_tvalid && o_s_axis_tready;
    assign sym             = i_s_axis_tdata;

    // Next-state decode: one transition per consumed symbol, lookahead shifts into the output beat.
    always_comb begin
        state_d    = state_q;
        tid_d      = tid_q;
        la_d       = la_q;
        la_vld_d   = la_vld_q;
        m_tvalid_d = m_tvalid_q && !i_m_axis_tready;
        m_tdata_d  = m_tdata_q;
        m_tid_d    = m_tid_q;
        m_tlast_d  = m_tlast_q;
        is_payload = 1'b0;
        is_end     = 1'b0;
        sym_res    = sym;
`ifdef SLIP_DEC_ERR_FLAG_EN
        err_d      = err_q;
        m_tuser_d  = m_tuser_q;
        esc_err    = 1'b0;
`endif

        if (accept) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (sym == SYMBOL_END) state_d = ST_ID;
                end
                ST_ID: begin
                    if (sym == SYMBOL_END) begin
                        state_d = ST_ID;
                    end else if (sym == SYMBOL_ESC) begin
                        state_d = ST_ID_ESC;
                    end else begin
                        tid_d   = sym[TID_WIDTH-1:0];
                        state_d = ST_DATA;
                    end
                end
                ST_ID_ESC: begin
                    if (sym == SYMBOL_ESC_END) begin
                        tid_d   = SYMBOL_END[TID_WIDTH-1:0];
                        state_d = ST_DATA;
                    end else if (sym == SYMBOL_ESC_ESC) begin
                        tid_d   = SYMBOL_ESC[TID_WIDTH-1:0];
                        state_d = ST_DATA;
                    end else if (sym == SYMBOL_END) begin
`ifdef SLIP_DEC_ERR_FLAG_EN
                        err_d   = 1'b1;
`endif
                        state_d = ST_ID;
                    end else begin
`ifdef SLIP_DEC_ERR_FLAG_EN
                        err_d   = 1'b1;
`endif
                        tid_d   = sym[TID_WIDTH-1:0];
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sym == SYMBOL_ESC)      state_d = ST_DATA_ESC;
                    else if (sym == SYMBOL_END) is_end = 1'b1;
                    else                        is_payload = 1'b1;
                end
                ST_DATA_ESC: begin
                    state_d = ST_DATA;
                    if (sym == SYMBOL_ESC_END) begin
                        sym_res    = SYMBOL_END;
                        is_payload = 1'b1;
                    end else if (sym == SYMBOL_ESC_ESC) begin
                        sym_res    = SYMBOL_ESC;
                        is_payload = 1'b1;
                    end else if (sym == SYMBOL_END) begin
`ifdef SLIP_DEC_ERR_FLAG_EN
                        esc_err    = 1'b1;
`endif
                        is_end     = 1'b1;
                    end else begin
`ifdef SLIP_DEC_ERR_FLAG_EN
                        esc_err    = 1'b1;
`endif
                        is_payload = 1'b1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        // Payload: push the previous lookahead out as a non-last beat, then refill it.
        if (is_payload) begin
            if (la_vld_q) begin
                m_tvalid_d = 1'b1;
                m_tdata_d  = la_q;
                m_tid_d    = tid_q;
                m_tlast_d  = 1'b0;
`ifdef SLIP_DEC_ERR_FLAG_EN
                m_tuser_d  = 1'b0;
`endif
            end
            la_d     = sym_res;
            la_vld_d = 1'b1;
`ifdef SLIP_DEC_ERR_FLAG_EN
            if (esc_err) err_d = 1'b1;
`endif
        end

        // Frame end: the lookahead (if any) is the tlast beat; an ID-only frame emits nothing.
        if (is_end) begin
            if (la_vld_q) begin
                m_tvalid_d = 1'b1;
                m_tdata_d  = la_q;
                m_tid_d    = tid_q;
                m_tlast_d  = 1'b1;
`ifdef SLIP_DEC_ERR_FLAG_EN
                m_tuser_d  = err_q || esc_err;
`endif
            end
            la_vld_d = 1'b0;
`ifdef SLIP_DEC_ERR_FLAG_EN
            err_d    = 1'b0;
`endif
            state_d  = ST_ID;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_HUNT;
            tid_q      <= '0;
            la_q       <= '0;
            la_vld_q   <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tid_q    <= '0;
            m_tlast_q  <= 1'b0;
`ifdef SLIP_DEC_ERR_FLAG_EN
            err_q      <= 1'b0;
            m_tuser_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tid_q      <= tid_d;
            la_q       <= la_d;
            la_vld_q   <= la_vld_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tid_q    <= m_tid_d;
            m_tlast_q  <= m_tlast_d;
`ifdef SLIP_DEC_ERR_FLAG_EN
            err_q      <= err_d;
            m_tuser_q  <= m_tuser_d;
`endif
        end
    end

    assign o_m_axis_tvalid = m_tvalid_q;
    assign o_m_axis_tdata  = m_tdata_q;
    assign o_m_axis_tid    = m_tid_q;
    assign o_m_axis_tlast  = m_tlast_q;
`ifdef SLIP_DEC_ERR_FLAG_EN
    assign o_m_axis_tuser  = m_tuser_q;
`endif

endmodule

// File: tb/tb_slip_axis_decoder_id.sv
// Self-checking bench for slip_axis_decoder_id: directed and random SLIP streams vs a frame-level model.
module tb_slip_axis_decoder_id;

    localparam int unsigned SW  = 8;
    localparam int unsigned TW  = 4;
    localparam logic [7:0]  END  = 8'hC0;
    localparam logic [7:0]  ESC  = 8'hDB;
    localparam logic [7:0]  EEND = 8'hDC;
    localparam logic [7:0]  EESC = 8'hDD;

    typedef struct packed {
        logic [7:0]  data;
        logic [3:0]  tid;
        logic        last;
        logic        user;
        logic [31:0] cyc;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          s_tvalid;
    logic          s_tready;
    logic [SW-1:0] s_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic [SW-1:0] m_tdata;
    logic [TW-1:0] m_tid;
    logic          m_tlast;
    logic          m_tuser;

    int            tests;
    int            fails;
    logic [31:0]   cyc;
    logic [7:0]    hist[$];
    beat_t         obs_q[$];
    beat_t         exp_q[$];
    int            n_checked;
    bit            stall_prev;
    beat_t         held;

    slip_axis_decoder_id dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_s_axis_tvalid (s_tvalid),
        .o_s_axis_tready (s_tready),
        .i_s_axis_tdata  (s_tdata),
        .o_m_axis_tvalid (m_tvalid),
        .i_m_axis_tready (m_tready),
        .o_m_axis_tdata  (m_tdata),
        .o_m_axis_tid    (m_tid),
        .o_m_axis_tlast  (m_tlast)
`ifdef SLIP_DEC_ERR_FLAG_EN
        ,
        .o_m_axis_tuser  (m_tuser)
`endif
    );

`ifndef SLIP_DEC_ERR_FLAG_EN
    assign m_tuser = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: split the stream on END, unescape each frame, first symbol is the ID.
    function automatic void model(input logic [7:0] s[$]);
        int         i;
        int         n;
        bit         carry;
        bit         err;
        bit         term;
        bit         dangling;
        int         sz;
        logic [7:0] seg[$];
        logic [7:0] u[$];
        logic [7:0] idsym;
        beat_t      b;
        exp_q.delete();
        n     = s.size();
        i     = 0;
        carry = 1'b0;
        while (i < n && s[i] != END) i++;
        if (i >= n) return;
        i++;
        while (i < n) begin
            seg.delete();
            u.delete();
            term = 1'b0;
            while (i < n && s[i] != END) begin
                seg.push_back(s[i]);
                i++;
            end
            if (i < n) begin
                term = 1'b1;
                i++;
            end
            err      = carry;
            dangling = 1'b0;
            for (int j = 0; j < seg.size(); j++) begin
                if (seg[j] == ESC) begin
                    if (j + 1 < seg.size()) begin
                        j++;
                        if (seg[j] == EEND)      u.push_back(END);
                        else if (seg[j] == EESC) u.push_back(ESC);
                        else begin
                            err = 1'b1;
                            u.push_back(seg[j]);
                        end
                    end else begin
                        dangling = 1'b1;
                    end
                end else begin
                    u.push_back(seg[j]);
                end
            end
            sz = u.size();
            if (sz > 0) idsym = u[0];
            else        idsym = 8'h00;
            if (!term) begin
                // Unterminated tail: everything but the last payload symbol has left the lookahead.
                for (int k = 1; k < sz - 1; k++) begin
                    b      = '0;
                    b.data = u[k];
                    b.tid  = idsym[3:0];
                    exp_q.push_back(b);
                end
                break;
            end
            if (dangling) err = 1'b1;
            if (sz == 0) begin
                if (dangling) carry = 1'b1;
                continue;
            end
            for (int k = 1; k < sz; k++) begin
                b      = '0;
                b.data = u[k];
                b.tid  = idsym[3:0];
                b.last = (k == sz - 1);
                b.user = (k == sz - 1) ? err : 1'b0;
                exp_q.push_back(b);
            end
            carry = 1'b0;
        end
    endfunction

    // One clock: drive after the falling edge, sample a little later, handshakes land on the next rise.
    task automatic cycle(input bit v, input logic [7:0] d, input bit r, output bit acc);
        beat_t b;
        @(negedge clk);
        s_tvalid = v;
        s_tdata  = d;
        m_tready = r;
        #1;
        chk("s_tready_rule", 32'(s_tready), 32'(!m_tvalid || m_tready));
        if (stall_prev) begin
            chk("stall_tvalid", 32'(m_tvalid), 32'd1);
            chk("stall_tdata",  32'(m_tdata),  32'(held.data));
            chk("stall_tid",    32'(m_tid),    32'(held.tid));
            chk("stall_tlast",  32'(m_tlast),  32'(held.last));
`ifdef SLIP_DEC_ERR_FLAG_EN
            chk("stall_tuser",  32'(m_tuser),  32'(held.user));
`endif
        end
        b.data = m_tdata;
        b.tid  = m_tid;
        b.last = m_tlast;
        b.user = m_tuser;
        b.cyc  = cyc;
        if (m_tvalid && m_tready) obs_q.push_back(b);
        stall_prev = m_tvalid && !m_tready;
        held       = b;
        acc        = v && s_tready;
        if (acc) hist.push_back(d);
        cyc++;
    endtask

    function automatic bit pick_ready(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return ~cyc[0];
            2:       return ($urandom_range(0, 2) != 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_stream(input logic [7:0] s[$], input int mode, input bit drain);
        int idx;
        int budget;
        bit acc;
        bit v;
        idx    = 0;
        budget = 0;
        while (idx < s.size() && budget < 20000) begin
            v = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            cycle(v, s[idx], pick_ready(mode), acc);
            if (acc) idx++;
            budget++;
        end
        chk("input_consumed", 32'(idx), 32'(s.size()));
        budget = 0;
        if (drain) begin
            cycle(1'b0, 8'h00, pick_ready(mode), acc);
            while (m_tvalid && budget < 200) begin
                cycle(1'b0, 8'h00, pick_ready(mode == 3 ? 0 : mode), acc);
                budget++;
            end
            chk("drain_done", 32'(m_tvalid), 32'd0);
        end else begin
            cycle(1'b0, 8'h00, 1'b0, acc);
        end
    endtask

    task automatic check_beats(input string tag);
        int m;
        model(hist);
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int k = n_checked; k < m; k++) begin
            chk({tag, "_tdata"}, 32'(obs_q[k].data), 32'(exp_q[k].data));
            chk({tag, "_tid"},   32'(obs_q[k].tid),  32'(exp_q[k].tid));
            chk({tag, "_tlast"}, 32'(obs_q[k].last), 32'(exp_q[k].last));
`ifdef SLIP_DEC_ERR_FLAG_EN
            chk({tag, "_tuser"}, 32'(obs_q[k].user), 32'(exp_q[k].user));
`endif
        end
        if (m > n_checked) n_checked = m;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({tag, "_tdata"},  32'(m_tdata),  32'd0);
        chk({tag, "_tid"},    32'(m_tid),    32'd0);
        chk({tag, "_tlast"},  32'(m_tlast),  32'd0);
        chk({tag, "_tuser"},  32'(m_tuser),  32'd0);
        chk({tag, "_tready"}, 32'(s_tready), 32'd1);
    endtask

    initial begin
        logic [7:0] stim[$];
        logic [7:0] t1[$];
        beat_t      t1_beats[$];
        int         base;
        int         r;

        tests      = 0;
        fails      = 0;
        cyc        = '0;
        n_checked  = 0;
        stall_prev = 1'b0;
        rst_n      = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        m_tready   = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Noise before first END is discarded, three beats with tid 3.
        t1 = {8'hAA, END, 8'h03, 8'h11, 8'h22, 8'h33, END};
        base = obs_q.size();
        run_stream(t1, 0, 1'b1);
        check_beats("t1");
        for (int k = base; k < obs_q.size(); k++) t1_beats.push_back(obs_q[k]);
        chk("t1_beats", 32'(t1_beats.size()), 32'd3);
        if (t1_beats.size() == 3) begin
            chk("t1_b2_data", 32'(t1_beats[2].data), 32'h33);
            chk("t1_b2_last", 32'(t1_beats[2].last), 32'd1);
            chk("t1_b0_last", 32'(t1_beats[0].last), 32'd0);
        end

        // Empty and ID-only frames vanish; escaped END/ESC payload.
        stim = {END, END, 8'h07, END, 8'h02, ESC, EEND, ESC, EESC, END};
        run_stream(stim, 0, 1'b1);
        check_beats("t2");

        // Same stream as t1 with a 1010 sink: identical beats, held stable under stall.
        base = obs_q.size();
        run_stream(t1, 1, 1'b1);
        check_beats("t3");
        chk("t3_beats", 32'(obs_q.size() - base), 32'(t1_beats.size()));
        for (int k = 0; k < t1_beats.size() && base + k < obs_q.size(); k++) begin
            chk("t3_vs_t1_data", 32'(obs_q[base + k].data), 32'(t1_beats[k].data));
            chk("t3_vs_t1_tid",  32'(obs_q[base + k].tid),  32'(t1_beats[k].tid));
            chk("t3_vs_t1_last", 32'(obs_q[base + k].last), 32'(t1_beats[k].last));
        end

        // Invalid escape in payload.
        base = obs_q.size();
        stim = {END, 8'h01, ESC, 8'h55, 8'h66, END};
        run_stream(stim, 0, 1'b1);
        check_beats("t4");
`ifdef SLIP_DEC_ERR_FLAG_EN
        if (obs_q.size() == base + 2) begin
            chk("t4_tuser0", 32'(obs_q[base].user),     32'd0);
            chk("t4_tuser1", 32'(obs_q[base + 1].user), 32'd1);
        end
`endif

        // Reset while a beat of frame tid 4 sits in the output register.
        stim = {END, 8'h04, 8'h10, 8'h20};
        run_stream(stim, 3, 1'b0);
        chk("t5_pending_tvalid", 32'(m_tvalid), 32'd1);
        chk("t5_pending_tdata",  32'(m_tdata),  32'h10);
        chk("t5_pending_tid",    32'(m_tid),    32'h4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_reset");
        hist.delete();
        obs_q.delete();
        n_checked  = 0;
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        stim = {END, 8'h05, 8'h30, END};
        run_stream(stim, 0, 1'b1);
        check_beats("t5");
        chk("t5_beats", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() == 1) begin
            chk("t5_tid",  32'(obs_q[0].tid),  32'h5);
            chk("t5_last", 32'(obs_q[0].last), 32'd1);
        end

        // 16 payload symbols at full rate: 16 beats on consecutive cycles.
        base = obs_q.size();
        stim.delete();
        stim.push_back(END);
        stim.push_back(8'h01);
        for (int k = 0; k < 16; k++) stim.push_back(8'hA0 + 8'(k));
        stim.push_back(END);
        run_stream(stim, 0, 1'b1);
        check_beats("t6");
        if (obs_q.size() >= base + 16) begin
            for (int k = 1; k < 16; k++)
                chk("t6_no_bubble", obs_q[base + k].cyc, obs_q[base].cyc + 32'(k));
            chk("t6_last_data", 32'(obs_q[base + 15].data), 32'hAF);
        end else begin
            chk("t6_beat_count", 32'(obs_q.size() - base), 32'd16);
        end

        // Random symbol soup heavy in END/ESC, with random and toggling sinks.
        for (int pass = 0; pass < 4; pass++) begin
            stim.delete();
            for (int k = 0; k < 250; k++) begin
                r = $urandom_range(0, 99);
                if (r < 12)      stim.push_back(END);
                else if (r < 24) stim.push_back(ESC);
                else if (r < 30) stim.push_back(($urandom_range(0, 1) != 0) ? EEND : EESC);
                else             stim.push_back(8'($urandom_range(0, 255)));
            end
            stim.push_back(END);
            run_stream(stim, (pass == 1) ? 1 : ((pass == 3) ? 0 : 2), 1'b1);
            check_beats("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
